axi_reg_bank: RTL and testbench

Parametrised AXI slave register bank: NUM_REGS registers of DATA_W bits, written and read over single-beat AXI transactions with IDs, byte strobes and error responses. It sits behind the system AXI interconnect and drives configuration and status registers for the counter datapath through a flattened register output. It accepts write address and write data independently, runs a separate read channel, and returns SLVERR on bad accesses.

---
 rtl/axi_reg_bank_if.sv | 44 ++++
 rtl/axi_reg_bank.sv | 197 +++++++++++++++++++
 tb/tb_axi_reg_bank.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_reg_bank_if.sv
// Single-beat AXI slave channels (AW, W, B, AR, R) for the register bank.
interface axi_reg_bank_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ID_W-1:0]     awid_i;
    logic [ADDR_W-1:0]   awaddr_i;
    logic                awvalid_i;
    logic                awready_o;
    logic [DATA_W-1:0]   wdata_i;
    logic [DATA_W/8-1:0] wstrb_i;
    logic                wlast_i;
    logic                wvalid_i;
    logic                wready_o;
    logic [ID_W-1:0]     bid_o;
    logic [1:0]          bresp_o;
    logic                bvalid_o;
    logic                bready_i;
    logic [ID_W-1:0]     arid_i;
    logic [ADDR_W-1:0]   araddr_i;
    logic                arvalid_i;
    logic                arready_o;
    logic [ID_W-1:0]     rid_o;
    logic [DATA_W-1:0]   rdata_o;
    logic [1:0]          rresp_o;
    logic                rlast_o;
    logic                rvalid_o;
    logic                rready_i;

    modport slave (
        input  awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
               arid_i, araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bid_o, bresp_o, bvalid_o,
               arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );

    modport master (
        output awid_i, awaddr_i, awvalid_i, wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
               arid_i, araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bid_o, bresp_o, bvalid_o,
               arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );
endinterface

// File: rtl/axi_reg_bank.sv
// AXI slave register bank: NUM_REGS x DATA_W registers with byte strobes,
// independent AW/W capture, concurrent read channel and SLVERR on bad accesses.
module axi_reg_bank_word #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                we,
    input  logic [DATA_W/8-1:0] strb,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            q <= RESET_VAL;
        end else if (we) begin
            for (int b = 0; b < DATA_W/8; b++)
                if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end
endmodule

module axi_reg_bank #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 8,
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       areset,
    axi_reg_bank_if.slave              bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);
    localparam int STRB_W = DATA_W/8;
    localparam int LSB    = $clog2(STRB_W);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } aw_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_req_t;

    typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_VALID}             rd_state_t;

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return ((a >> LSB) >= ADDR_W'(NUM_REGS)) || (a[LSB-1:0] != '0);
    endfunction

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             we;

    wr_state_t         wr_state;
    aw_req_t           aw_q, aw_cur;
    w_req_t            w_q, w_cur;
    logic              awready, wready, bvalid;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              aw_hs, w_hs, commit, wr_good;
    logic [ADDR_W-1:0] wr_idx;

    rd_state_t         rd_state;
    logic              arready, rvalid, rd_bad;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata, rd_word;
    logic [1:0]        rresp;
    logic [ADDR_W-1:0] rd_idx;

    assign aw_hs = bus.awvalid_i && awready;
    assign w_hs  = bus.wvalid_i && wready;

    // The half that arrived first is replayed from its holding register.
    assign aw_cur = (wr_state == HAVE_AW) ? aw_q : {bus.awid_i, bus.awaddr_i};
    assign w_cur  = (wr_state == HAVE_W)  ? w_q  : {bus.wdata_i, bus.wstrb_i, bus.wlast_i};

    assign commit  = (wr_state == IDLE    && aw_hs && w_hs) ||
                     (wr_state == HAVE_AW && w_hs) ||
                     (wr_state == HAVE_W  && aw_hs);
    assign wr_good = !addr_bad(aw_cur.addr) && w_cur.last;
    assign wr_idx  = aw_cur.addr >> LSB;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        assign we[i] = commit && wr_good && (wr_idx == ADDR_W'(i));
        axi_reg_bank_word #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_word (
            .clk   (clk),
            .areset(areset),
            .we    (we[i]),
            .strb  (w_cur.strb),
            .wdata (w_cur.data),
            .q     (regs[i])
        );
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state <= IDLE;
            awready  <= 1'b1;
            wready   <= 1'b1;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= 2'b00;
            aw_q     <= '0;
            w_q      <= '0;
        end else if (commit) begin
            wr_state <= RESP;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bid      <= aw_cur.id;
            bresp    <= wr_good ? 2'b00 : 2'b10;
        end else begin
            case (wr_state)
                IDLE: begin
                    if (aw_hs) begin
                        wr_state <= HAVE_AW;
                        awready  <= 1'b0;
                        aw_q     <= aw_cur;
                    end else if (w_hs) begin
                        wr_state <= HAVE_W;
                        wready   <= 1'b0;
                        w_q      <= w_cur;
                    end
                end
                RESP: begin
                    if (bus.bready_i) begin
                        wr_state <= IDLE;
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Out-of-range indices fall through to zero.
    assign rd_idx = bus.araddr_i >> LSB;
    assign rd_bad = addr_bad(bus.araddr_i);
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_idx == ADDR_W'(i)) rd_word = regs[i];
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rd_state <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= 2'b00;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (bus.arvalid_i) begin
                        rd_state <= R_VALID;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rid      <= bus.arid_i;
                        rdata    <= rd_bad ? '0 : rd_word;
                        rresp    <= rd_bad ? 2'b10 : 2'b00;
                    end
                end
                R_VALID: begin
                    if (bus.rready_i) begin
                        rd_state <= R_IDLE;
                        arready  <= 1'b1;
                        rvalid   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.awready_o = awready;
    assign bus.wready_o  = wready;
    assign bus.bvalid_o  = bvalid;
    assign bus.bid_o     = bid;
    assign bus.bresp_o   = bresp;
    assign bus.arready_o = arready;
    assign bus.rvalid_o  = rvalid;
    assign bus.rlast_o   = rvalid;
    assign bus.rid_o     = rid;
    assign bus.rdata_o   = rdata;
    assign bus.rresp_o   = rresp;
    assign regs_o        = regs;
endmodule

// File: tb/tb_axi_reg_bank.sv
// Scoreboard bench for axi_reg_bank: expected B/R responses are queued when
// stimulus is driven and compared when the DUT presents them.
module tb_axi_reg_bank;
    localparam int DATA_W = 32, NUM_REGS = 8, ID_W = 4, ADDR_W = 32;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    int checks = 0, errors = 0;

    typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp;} r_exp_t;
    b_exp_t b_q[$];
    r_exp_t r_q[$];
    logic [31:0] model [NUM_REGS];

    always #5 clk = ~clk;

    axi_reg_bank_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_reg_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ID_W(ID_W), .ADDR_W(ADDR_W),
                   .RESET_VAL(32'h0)) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus),
        .regs_o(regs_o)
    );

    function automatic logic bad(input logic [31:0] a);
        return ((a >> 2) >= 32'd8) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    task automatic idle_inputs();
        bus.awid_i = '0; bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
        bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.bready_i = 1'b0;
        bus.arid_i = '0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
        bus.rready_i = 1'b0;
    endtask

    task automatic apply_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic last);
        if (!bad(addr) && last) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[int'(addr >> 2)][b*8 +: 8] = data[b*8 +: 8];
            b_q.push_back('{id: id, resp: 2'b00});
        end else begin
            b_q.push_back('{id: id, resp: 2'b10});
        end
    endtask

    task automatic send_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        bus.awid_i = id; bus.awaddr_i = addr; bus.awvalid_i = 1'b1;
        bus.wdata_i = data; bus.wstrb_i = strb; bus.wlast_i = last; bus.wvalid_i = 1'b1;
        while (!(bus.awready_o && bus.wready_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        apply_write(id, addr, data, strb, last);
    endtask

    task automatic send_read(input logic [3:0] id, input logic [31:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        bus.arid_i = id; bus.araddr_i = addr; bus.arvalid_i = 1'b1;
        while (!bus.arready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus.arvalid_i = 1'b0;
        r_q.push_back('{id: id, data: bad(addr) ? 32'h0 : model[int'(addr >> 2)],
                       resp: bad(addr) ? 2'b10 : 2'b00});
    endtask

    task automatic wait_b(output logic got, output logic [3:0] id, output logic [1:0] resp);
        got = 1'b0; id = '0; resp = '0;
        bus.bready_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.bvalid_o) begin
                got = 1'b1; id = bus.bid_o; resp = bus.bresp_o;
                @(posedge clk); #1;
                break;
            end
        end
        bus.bready_i = 1'b0;
    endtask

    task automatic wait_r(output logic got, output logic [3:0] id, output logic [31:0] data,
                          output logic [1:0] resp, output logic last);
        got = 1'b0; id = '0; data = '0; resp = '0; last = 1'b0;
        bus.rready_i = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.rvalid_o) begin
                got = 1'b1; id = bus.rid_o; data = bus.rdata_o; resp = bus.rresp_o; last = bus.rlast_o;
                @(posedge clk); #1;
                break;
            end
        end
        bus.rready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 areset = 1'b0;
        #10;
        checks++; if (regs_o !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", regs_o); end
        checks++; if ({bus.awready_o, bus.wready_o, bus.arready_o} !== 3'b111) begin
            errors++; $display("FAIL reset_ready got %b want 111", {bus.awready_o, bus.wready_o, bus.arready_o}); end
        checks++; if ({bus.bvalid_o, bus.rvalid_o, bus.rlast_o} !== 3'b000) begin
            errors++; $display("FAIL reset_valid got %b want 000", {bus.bvalid_o, bus.rvalid_o, bus.rlast_o}); end
        checks++; if ({bus.bid_o, bus.bresp_o, bus.rid_o, bus.rdata_o, bus.rresp_o} !== '0) begin
            errors++; $display("FAIL reset_resp got %h want 0", {bus.bid_o, bus.bresp_o, bus.rid_o, bus.rdata_o, bus.rresp_o}); end
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        @(negedge clk) areset = 1'b1;
    endtask

    task automatic test_write_read();
        b_exp_t eb; r_exp_t er;
        logic got, last; logic [3:0] id; logic [1:0] resp; logic [31:0] data;
        send_write(4'd3, 32'h08, 32'hDEADBEEF, 4'hF, 1'b1);
        checks++; if (bus.bvalid_o !== 1'b1) begin errors++; $display("FAIL wr_bvalid got %b want 1", bus.bvalid_o); end
        checks++; if (regs_o[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_reg2 got %h want deadbeef", regs_o[95:64]); end
        wait_b(got, id, resp); eb = b_q.pop_front();
        checks++; if (!got || id !== eb.id || resp !== eb.resp || id !== 4'd3) begin
            errors++; $display("FAIL wr_b got %b id=%h resp=%b want id=%h resp=%b", got, id, resp, eb.id, eb.resp); end
        send_read(4'd5, 32'h08);
        wait_r(got, id, data, resp, last); er = r_q.pop_front();
        checks++; if (!got || id !== er.id || data !== er.data || resp !== er.resp || last !== 1'b1 || data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_r got %b id=%h data=%h resp=%b last=%b want id=%h data=%h resp=%b last=1",
                               got, id, data, resp, last, er.id, er.data, er.resp); end
    endtask

    task automatic test_w_before_aw();
        b_exp_t eb; logic got; logic [3:0] id; logic [1:0] resp;
        send_write(4'd1, 32'h04, 32'hFFFFFFFF, 4'hF, 1'b1);
        wait_b(got, id, resp); eb = b_q.pop_front();
        checks++; if (!got || id !== eb.id || resp !== eb.resp) begin
            errors++; $display("FAIL wfirst_pre got %b id=%h resp=%b want id=%h resp=%b", got, id, resp, eb.id, eb.resp); end
        @(negedge clk);
        bus.wdata_i = 32'h11223344; bus.wstrb_i = 4'h5; bus.wlast_i = 1'b1; bus.wvalid_i = 1'b1;
        @(posedge clk); #1;
        bus.wvalid_i = 1'b0; bus.wdata_i = 32'hA5A5A5A5; bus.wstrb_i = 4'hF; bus.wlast_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.wready_o !== 1'b0 || bus.awready_o !== 1'b1 || bus.bvalid_o !== 1'b0) begin
                errors++; $display("FAIL wfirst_hold cyc %0d got wready=%b awready=%b bvalid=%b want 0 1 0",
                                   i, bus.wready_o, bus.awready_o, bus.bvalid_o); end
            if (i < 2) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        bus.awid_i = 4'd7; bus.awaddr_i = 32'h04; bus.awvalid_i = 1'b1;
        @(posedge clk); #1;
        bus.awvalid_i = 1'b0;
        apply_write(4'd7, 32'h04, 32'h11223344, 4'h5, 1'b1);
        checks++; if (regs_o[63:32] !== 32'hFF22FF44 || bus.bvalid_o !== 1'b1) begin
            errors++; $display("FAIL wfirst_merge got %h bvalid=%b want ff22ff44 1", regs_o[63:32], bus.bvalid_o); end
        wait_b(got, id, resp); eb = b_q.pop_front();
        checks++; if (!got || id !== eb.id || resp !== eb.resp) begin
            errors++; $display("FAIL wfirst_b got %b id=%h resp=%b want id=%h resp=%b", got, id, resp, eb.id, eb.resp); end
        repeat (2) @(posedge clk); #1;
        checks++; if (bus.bvalid_o !== 1'b0) begin errors++; $display("FAIL wfirst_single got bvalid=%b want 0", bus.bvalid_o); end
    endtask

    task automatic test_errors();
        b_exp_t eb; r_exp_t er;
        logic got, last; logic [3:0] id; logic [1:0] resp; logic [31:0] data;
        logic [31:0] addrs [4];
        logic        lasts [4];
        addrs = '{32'h20, 32'h06, 32'h0C, 32'h1C};
        lasts = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send_write(4'd2, addrs[i], 32'h12345678 + i, 4'hF, lasts[i]);
            wait_b(got, id, resp); eb = b_q.pop_front();
            checks++; if (!got || id !== eb.id || resp !== eb.resp) begin
                errors++; $display("FAIL err_b[%0d] got %b id=%h resp=%b want id=%h resp=%b", i, got, id, resp, eb.id, eb.resp); end
            checks++; if (regs_o !== model_flat()) begin
                errors++; $display("FAIL err_regs[%0d] got %h want %h", i, regs_o, model_flat()); end
        end
        send_read(4'd8, 32'h1C);
        wait_r(got, id, data, resp, last); er = r_q.pop_front();
        checks++; if (!got || id !== er.id || data !== er.data || resp !== 2'b00) begin
            errors++; $display("FAIL err_rd1c got id=%h data=%h resp=%b want id=%h data=%h resp=00", id, data, resp, er.id, er.data); end
        send_read(4'd9, 32'h24);
        wait_r(got, id, data, resp, last); er = r_q.pop_front();
        checks++; if (!got || id !== er.id || data !== 32'h0 || resp !== 2'b10) begin
            errors++; $display("FAIL err_rd24 got id=%h data=%h resp=%b want id=%h data=0 resp=10", id, data, resp, er.id); end
    endtask

    task automatic test_backpressure();
        b_exp_t eb; r_exp_t er;
        logic got, last; logic [3:0] id; logic [1:0] resp; logic [31:0] data;
        send_write(4'd6, 32'h10, 32'h0BADF00D, 4'hF, 1'b1);
        send_read(4'd9, 32'h10);
        wait_r(got, id, data, resp, last); er = r_q.pop_front();
        checks++; if (!got || id !== er.id || data !== er.data || resp !== er.resp) begin
            errors++; $display("FAIL bp_read got %b id=%h data=%h resp=%b want id=%h data=%h resp=%b",
                               got, id, data, resp, er.id, er.data, er.resp); end
        for (int i = 0; i < 3; i++) begin
            checks++; if ({bus.bvalid_o, bus.awready_o, bus.wready_o} !== 3'b100 || bus.bid_o !== 4'd6) begin
                errors++; $display("FAIL bp_hold cyc %0d got bvalid/awready/wready=%b bid=%h want 100 6",
                                   i, {bus.bvalid_o, bus.awready_o, bus.wready_o}, bus.bid_o); end
            @(posedge clk); #1;
        end
        wait_b(got, id, resp); eb = b_q.pop_front();
        checks++; if (!got || id !== eb.id || resp !== eb.resp) begin
            errors++; $display("FAIL bp_b got %b id=%h resp=%b want id=%h resp=%b", got, id, resp, eb.id, eb.resp); end
        checks++; if ({bus.awready_o, bus.wready_o} !== 2'b11) begin
            errors++; $display("FAIL bp_release got %b want 11", {bus.awready_o, bus.wready_o}); end
    endtask

    task automatic test_back_to_back();
        b_exp_t eb; r_exp_t er;
        logic got, last; logic [3:0] id; logic [1:0] resp; logic [31:0] data, addr;
        for (int i = 0; i < 8; i++) begin
            addr = 32'($urandom_range(0, 9)) * 4;
            send_write(4'(i), addr, $urandom, 4'($urandom_range(0, 15)), 1'b1);
            wait_b(got, id, resp); eb = b_q.pop_front();
            checks++; if (!got || id !== eb.id || resp !== eb.resp || regs_o !== model_flat()) begin
                errors++; $display("FAIL b2b_wr[%0d] got %b id=%h resp=%b regs=%h want id=%h resp=%b regs=%h",
                                   i, got, id, resp, regs_o, eb.id, eb.resp, model_flat()); end
            send_read(4'(i + 1), 32'($urandom_range(0, 9)) * 4);
            wait_r(got, id, data, resp, last); er = r_q.pop_front();
            checks++; if (!got || id !== er.id || data !== er.data || resp !== er.resp || last !== 1'b1) begin
                errors++; $display("FAIL b2b_rd[%0d] got %b id=%h data=%h resp=%b want id=%h data=%h resp=%b",
                                   i, got, id, data, resp, er.id, er.data, er.resp); end
        end
    endtask

    task automatic test_async_reset();
        send_write(4'd2, 32'h00, 32'h55AA55AA, 4'hF, 1'b1);
        checks++; if (regs_o[31:0] !== 32'h55AA55AA || bus.bvalid_o !== 1'b1) begin
            errors++; $display("FAIL arst_pre got %h bvalid=%b want 55aa55aa 1", regs_o[31:0], bus.bvalid_o); end
        #2 areset = 1'b0;
        #1;
        checks++; if (bus.bvalid_o !== 1'b0 || regs_o !== '0) begin
            errors++; $display("FAIL arst_drop got bvalid=%b regs=%h want 0 0", bus.bvalid_o, regs_o); end
        checks++; if ({bus.awready_o, bus.wready_o, bus.arready_o} !== 3'b111) begin
            errors++; $display("FAIL arst_ready got %b want 111", {bus.awready_o, bus.wready_o, bus.arready_o}); end
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        b_q.delete();
        @(negedge clk) areset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
